demux4x32_reg: RTL and testbench
================================

DEMUX4X32_REG -- requirements
Module: demux4x32_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the input and of each output lane.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of the accepted-transfer counter.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  upstream offers a word this cycle.
REQ-006 Port in_ready  output  1  block accepts the offered word this cycle.
REQ-007 Port in_sel  input  2  destination lane (0..3) for the offered word.
REQ-008 Port in_data  input  WIDTH  offered word.
REQ-009 Port out_valid  output  4  bit i set means lane i holds an undelivered word.
REQ-010 Port out_ready  input  4  bit i set means lane i consumer takes its word this cycle.
REQ-011 Ports out_data0, out_data1, out_data2, out_data3  output  WIDTH each  lane holding registers.
REQ-012 Port busy  output  1  OR of out_valid.
REQ-013 Port xfer_cnt  output  CNTW  count of accepted input words.

Function
REQ-014 Each lane SHALL be a one-entry holding register with state EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
REQ-015 in_ready SHALL be combinational: out_valid[in_sel]==0 OR out_ready[in_sel]==1, independent of in_valid.
REQ-016 An input accept SHALL occur on an edge where in_valid && in_ready; at most one accept per cycle.
REQ-017 On accept, lane in_sel SHALL load in_data and go FULL; the word SHALL appear on out_data<in_sel> with out_valid set in the cycle after the accept edge (latency 1).
REQ-018 A lane delivery SHALL occur on an edge where out_valid[i] && out_ready[i]; the lane SHALL go EMPTY unless the same edge accepts a word for lane i.
REQ-019 Simultaneous delivery and accept on the same lane SHALL leave the lane FULL holding the new word with no bubble.
REQ-020 Deliveries on any subset of lanes and one accept on any lane SHALL all occur on the same edge, each lane independently.
REQ-021 A FULL lane with out_ready[i]=0 SHALL hold out_data<i> and out_valid[i] stable until delivered.
REQ-022 out_data<i> SHALL keep its last value when EMPTY; it SHALL change only on accept into lane i.
REQ-023 A FULL lane not selected by in_sel SHALL NOT block accepts to other lanes.
REQ-024 xfer_cnt SHALL increment by 1 on each accept and wrap from 2^CNTW-1 to 0.
REQ-025 in_sel and in_data SHALL be ignored when in_valid=0; out_ready bits of EMPTY lanes SHALL be ignored.
REQ-026 busy SHALL be combinational from the registered out_valid bits.

Reset
REQ-027 While rst=1, regardless of clk, out_valid SHALL be 4'b0000, out_data0..3 SHALL be 0, xfer_cnt SHALL be 0, busy SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all held words immediately; no delivery SHALL be reported on the reset edge.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept (in_ready=1 for any in_sel).

Verification
REQ-030 Reset then in_valid=1, in_sel=2, in_data=0xDEADBEEF, out_ready=0 -> in_ready=1; next cycle out_valid=4'b0100, out_data2=0xDEADBEEF, busy=1, xfer_cnt=1.
REQ-031 Lane 2 FULL, out_ready=0, offer in_sel=2 -> in_ready=0, lane 2 unchanged; offer in_sel=0 data 0x11 -> accepted, out_valid=4'b0101.
REQ-032 Lane 1 FULL with 0xA, out_ready[1]=1, offer in_sel=1 data 0xB -> in_ready=1; next cycle out_valid[1]=1, out_data1=0xB, no empty cycle.
REQ-033 All four lanes FULL, out_ready=4'b1111, in_valid=0 -> next cycle out_valid=0, busy=0, out_data0..3 unchanged.
REQ-034 xfer_cnt preloaded to 0xFFFF by 65535 accepts, one more accept -> xfer_cnt=0x0000.
REQ-035 Lanes 0 and 3 FULL, rst pulsed between clock edges -> out_valid=0, out_data0..3=0, xfer_cnt=0 before the next edge.

Source files
------------

// File: rtl/demux4x32_reg.sv
// rtl/demux4x32_reg.sv - one-to-four demultiplexer with a one-entry holding register per lane
module demux4x32_reg #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy,
    output logic [CNTW-1:0]  xfer_cnt
);

    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];
    logic [CNTW-1:0]  cnt_q;
    logic             accept;
    logic [3:0]       load;

    // A lane can take a word when it is empty or is being drained on this same edge.
    assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    // One-hot load strobe for the selected lane; other lanes are untouched by the input side.
    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
    end

    // Lane occupancy: a load wins over a delivery, so drain-and-refill leaves no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    valid_q[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Lane data only changes on a load, so an emptied lane keeps showing its last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    // Accepted-word counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign busy      = |valid_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux4x32_reg.sv
// tb/tb_demux4x32_reg.sv - scoreboard bench for demux4x32_reg
module tb_demux4x32_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic        busy;
    logic [15:0] xfer_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q0[$], q1[$], q2[$], q3[$];

    logic [3:0]  mvalid;
    logic [31:0] mdata [4];
    logic [15:0] mcnt;

    demux4x32_reg #(.WIDTH(32), .CNTW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic q_push(input logic [1:0] lane, input logic [31:0] d);
        case (lane)
            2'd0: q0.push_back(d);
            2'd1: q1.push_back(d);
            2'd2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    function automatic logic [31:0] lane_data(input int lane);
        case (lane)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Monitor: every delivery the DUT presents is matched against the oldest word sent to that lane.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    logic [31:0] e;
                    int sz;
                    case (i)
                        0: sz = q0.size();
                        1: sz = q1.size();
                        2: sz = q2.size();
                        default: sz = q3.size();
                    endcase
                    if (sz == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL deliver_unexpected lane %0d: got %0h expected none", i, lane_data(i));
                    end else begin
                        case (i)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            2: e = q2.pop_front();
                            default: e = q3.pop_front();
                        endcase
                        chk($sformatf("deliver_lane%0d", i), {32'h0, lane_data(i)}, {32'h0, e});
                    end
                end
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_out_valid"}, {60'h0, out_valid}, {60'h0, mvalid});
        chk({tag, "_busy"}, {63'h0, busy}, {63'h0, |mvalid});
        chk({tag, "_xfer_cnt"}, {48'h0, xfer_cnt}, {48'h0, mcnt});
        chk({tag, "_data0"}, {32'h0, out_data0}, {32'h0, mdata[0]});
        chk({tag, "_data1"}, {32'h0, out_data1}, {32'h0, mdata[1]});
        chk({tag, "_data2"}, {32'h0, out_data2}, {32'h0, mdata[2]});
        chk({tag, "_data3"}, {32'h0, out_data3}, {32'h0, mdata[3]});
    endtask

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic step(input string tag, input logic v, input logic [1:0] sel,
                        input logic [31:0] d, input logic [3:0] rdy);
        logic        exp_rdy;
        logic        acc;
        logic [3:0]  nv;
        logic [31:0] nd [4];
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        exp_rdy = !mvalid[sel] || rdy[sel];
        chk({tag, "_in_ready"}, {63'h0, in_ready}, {63'h0, exp_rdy});
        acc = v && exp_rdy;
        if (acc) q_push(sel, d);
        for (int i = 0; i < 4; i++) begin
            nd[i] = mdata[i];
            nv[i] = mvalid[i];
            if (acc && sel == 2'(i)) begin
                nv[i] = 1'b1;
                nd[i] = d;
            end else if (rdy[i]) begin
                nv[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        mvalid = nv;
        for (int i = 0; i < 4; i++) mdata[i] = nd[i];
        if (acc) mcnt = mcnt + 16'd1;
        check_state(tag);
    endtask

    // Pulses reset between edges and checks the asynchronous clear before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #2;
        mvalid = 4'b0000;
        mcnt   = 16'h0;
        for (int i = 0; i < 4; i++) mdata[i] = 32'h0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        check_state(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b0000;
        do_reset("reset");

        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #0;
            chk($sformatf("post_reset_ready_sel%0d", s), {63'h0, in_ready}, 64'h1);
        end

        step("basic", 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        chk("basic_ov", {60'h0, out_valid}, 64'h4);
        chk("basic_d2", {32'h0, out_data2}, 64'hDEADBEEF);
        chk("basic_cnt", {48'h0, xfer_cnt}, 64'h1);

        step("blocked", 1'b1, 2'd2, 32'h5555_5555, 4'b0000);
        chk("blocked_d2", {32'h0, out_data2}, 64'hDEADBEEF);
        step("other_lane", 1'b1, 2'd0, 32'h0000_0011, 4'b0000);
        chk("other_lane_ov", {60'h0, out_valid}, 64'h5);

        step("fill1", 1'b1, 2'd1, 32'h0000_000A, 4'b0000);
        step("refill1", 1'b1, 2'd1, 32'h0000_000B, 4'b0010);
        chk("refill1_ov1", {63'h0, out_valid[1]}, 64'h1);
        chk("refill1_d1", {32'h0, out_data1}, 64'hB);

        step("fill3", 1'b1, 2'd3, 32'h3333_3333, 4'b0000);
        chk("all_full", {60'h0, out_valid}, 64'hF);
        step("drain_all", 1'b0, 2'd1, 32'hFFFF_FFFF, 4'b1111);
        chk("drain_busy", {63'h0, busy}, 64'h0);
        chk("drain_d3", {32'h0, out_data3}, 64'h3333_3333);

        step("idle_ready_ignored", 1'b0, 2'd3, 32'h1234_5678, 4'b1111);
        step("fill0", 1'b1, 2'd0, 32'hA0A0_A0A0, 4'b0000);
        step("fill2", 1'b1, 2'd2, 32'hC2C2_C2C2, 4'b0000);
        step("mixed", 1'b1, 2'd1, 32'h7777_7777, 4'b0101);
        chk("mixed_ov", {60'h0, out_valid}, 64'h2);
        step("drain1", 1'b0, 2'd0, 32'h0, 4'b0010);

        while (mcnt != 16'hFFFF) begin
            step("count", 1'b1, 2'd0, {16'h0, mcnt}, 4'b0001);
        end
        chk("cnt_max", {48'h0, xfer_cnt}, 64'hFFFF);
        step("wrap", 1'b1, 2'd0, 32'hCAFE_F00D, 4'b0001);
        chk("cnt_wrap", {48'h0, xfer_cnt}, 64'h0);

        step("pre_rst0", 1'b1, 2'd0, 32'h0101_0101, 4'b0001);
        step("pre_rst3", 1'b1, 2'd3, 32'h0303_0303, 4'b0000);
        chk("pre_rst_ov", {60'h0, out_valid}, 64'h9);
        do_reset("mid_reset");

        step("after_reset", 1'b1, 2'd3, 32'h0BAD_F00D, 4'b0000);
        step("after_reset_drain", 1'b0, 2'd0, 32'h0, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
